// File: rtl/sm_dmem_responder_pkg.sv
// Shared settings for the data-memory responder and the CPU that drives it:
// region codes, peripheral register offsets and timer control bit positions.
package sm_dmem_responder_pkg;

    localparam logic [3:0] REGION_RAM    = 4'h0;
    localparam logic [3:0] REGION_PERIPH = 4'h8;

    typedef enum logic [3:0] {
        OFF_GPIO_OUT = 4'd0,
        OFF_GPIO_IN  = 4'd1,
        OFF_TMR_CNT  = 4'd2,
        OFF_TMR_CMP  = 4'd3,
        OFF_TMR_CTRL = 4'd4,
        OFF_TMR_STAT = 4'd5,
        OFF_TMR_PRE  = 4'd6
    } periph_off_e;

    localparam int CTRL_EN    = 0;
    localparam int CTRL_AUTO  = 1;
    localparam int CTRL_IRQEN = 2;

endpackage

// File: rtl/sm_dmem_responder_timer.sv
// Prescaled 32-bit timer with compare match, W1C status and level interrupt.
// Register writes arrive from the peripheral decoder in the top module.
module sm_timer
    import sm_dmem_responder_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        we,
    input  logic [3:0]  off,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    logic [31:0] cnt_q, cnt_d;
    logic [31:0] cmp_q, cmp_d;
    logic [31:0] pre_q, pre_d;
    logic [31:0] pre_cnt_q, pre_cnt_d;
    logic [2:0]  ctrl_q, ctrl_d;
    logic        match_q, match_d;
    logic        irq_q, irq_d;

    logic wr_cnt, wr_cmp, wr_pre, wr_ctrl, wr_stat;
    logic tick, hit;

    always_comb begin
        wr_cnt  = we && (off == OFF_TMR_CNT);
        wr_cmp  = we && (off == OFF_TMR_CMP);
        wr_pre  = we && (off == OFF_TMR_PRE);
        wr_ctrl = we && (off == OFF_TMR_CTRL);
        wr_stat = we && (off == OFF_TMR_STAT);

        tick = ctrl_q[CTRL_EN] && (pre_cnt_q == pre_q);
        hit  = tick && (cnt_q == cmp_q);

        cnt_d     = cnt_q;
        cmp_d     = cmp_q;
        pre_d     = pre_q;
        pre_cnt_d = pre_cnt_q;
        ctrl_d    = ctrl_q;
        match_d   = match_q;

        if (ctrl_q[CTRL_EN])
            pre_cnt_d = tick ? 32'd0 : pre_cnt_q + 32'd1;
        if (tick)
            cnt_d = (hit && ctrl_q[CTRL_AUTO]) ? 32'd0 : cnt_q + 32'd1;

        // CPU writes take precedence over the free-running update
        if (wr_cnt)
            cnt_d = wdata;
        if (wr_cmp)
            cmp_d = wdata;
        if (wr_pre) begin
            pre_d     = wdata;
            pre_cnt_d = 32'd0;
        end
        if (wr_ctrl) begin
            ctrl_d = wdata[2:0];
            if (!wdata[CTRL_EN])
                pre_cnt_d = 32'd0;
        end

        if (wr_stat && wdata[0])
            match_d = 1'b0;
        if (hit && !wr_cnt)
            match_d = 1'b1;

        irq_d = match_q & ctrl_q[CTRL_IRQEN];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            cmp_q     <= '0;
            pre_q     <= '0;
            pre_cnt_q <= '0;
            ctrl_q    <= '0;
            match_q   <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            cmp_q     <= cmp_d;
            pre_q     <= pre_d;
            pre_cnt_q <= pre_cnt_d;
            ctrl_q    <= ctrl_d;
            match_q   <= match_d;
            irq_q     <= irq_d;
        end
    end

    always_comb begin
        rdata = 32'd0;
        unique case (off)
            OFF_TMR_CNT:  rdata = cnt_q;
            OFF_TMR_CMP:  rdata = cmp_q;
            OFF_TMR_CTRL: rdata = {29'd0, ctrl_q};
            OFF_TMR_STAT: rdata = {31'd0, match_q};
            OFF_TMR_PRE:  rdata = pre_q;
            default:      rdata = 32'd0;
        endcase
    end

    assign irq = irq_q;

endmodule

// File: rtl/sm_dmem_responder.sv
// Zero-wait-state data memory responder: word RAM, GPIO and a timer
// behind a single combinational-read CPU data port.
module sm_dmem_responder
    import sm_dmem_responder_pkg::*;
#(
    parameter int RAM_AW = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] dmAddr,
    input  logic        dmWe,
    input  logic [31:0] dmWData,
    output logic [31:0] dmRData,
    input  logic [15:0] gpioIn,
    output logic [15:0] gpioOut,
    output logic        irqTimer
);

    logic [31:0] mem_q [2**RAM_AW];

    logic [3:0]        region;
    logic [3:0]        off;
    logic [RAM_AW-1:0] ram_idx;
    logic              ram_sel, periph_sel;
    logic              ram_we, periph_we;

    logic [15:0] gpio_out_q, gpio_out_d;
    logic [15:0] sync1_q, sync2_q;
    logic [31:0] tmr_rdata;
    logic        unused_addr;

    assign region      = dmAddr[31:28];
    assign off         = dmAddr[5:2];
    assign ram_idx     = dmAddr[RAM_AW+1:2];
    assign ram_sel     = (region == REGION_RAM);
    assign periph_sel  = (region == REGION_PERIPH);
    assign ram_we      = ram_sel && dmWe;
    assign periph_we   = periph_sel && dmWe;
    assign unused_addr = ^dmAddr;

    // RAM is deliberately left out of reset so software data survives it
    always_ff @(posedge clk) begin
        if (ram_we)
            mem_q[ram_idx] <= dmWData;
    end

    always_comb begin
        gpio_out_d = gpio_out_q;
        if (periph_we && off == OFF_GPIO_OUT)
            gpio_out_d = dmWData[15:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gpio_out_q <= '0;
            sync1_q    <= '0;
            sync2_q    <= '0;
        end else begin
            gpio_out_q <= gpio_out_d;
            sync1_q    <= gpioIn;
            sync2_q    <= sync1_q;
        end
    end

    sm_timer u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (periph_we),
        .off   (off),
        .wdata (dmWData),
        .rdata (tmr_rdata),
        .irq   (irqTimer)
    );

    always_comb begin
        dmRData = 32'd0;
        if (ram_sel) begin
            dmRData = mem_q[ram_idx];
        end else if (periph_sel) begin
            unique case (off)
                OFF_GPIO_OUT: dmRData = {16'd0, gpio_out_q};
                OFF_GPIO_IN:  dmRData = {16'd0, sync2_q};
                default:      dmRData = tmr_rdata;
            endcase
        end
    end

    assign gpioOut = gpio_out_q;

endmodule

// File: tb/tb_sm_dmem_responder.sv
// Directed bench for sm_dmem_responder: vector table for RAM/decode,
// hand sequences for GPIO sync latency, timer match, priorities and reset.
module tb_sm_dmem_responder;

    localparam int RAM_AW = 6;

    localparam logic [31:0] A_GOUT = 32'h8000_0000;
    localparam logic [31:0] A_GIN  = 32'h8000_0004;
    localparam logic [31:0] A_CNT  = 32'h8000_0008;
    localparam logic [31:0] A_CMP  = 32'h8000_000C;
    localparam logic [31:0] A_CTRL = 32'h8000_0010;
    localparam logic [31:0] A_STAT = 32'h8000_0014;
    localparam logic [31:0] A_PRE  = 32'h8000_0018;

    logic        clk;
    logic        rst_n;
    logic [31:0] dmAddr;
    logic        dmWe;
    logic [31:0] dmWData;
    logic [31:0] dmRData;
    logic [15:0] gpioIn;
    logic [15:0] gpioOut;
    logic        irqTimer;

    int nchk = 0;
    int nerr = 0;

    sm_dmem_responder #(.RAM_AW(RAM_AW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .dmAddr   (dmAddr),
        .dmWe     (dmWe),
        .dmWData  (dmWData),
        .dmRData  (dmRData),
        .gpioIn   (gpioIn),
        .gpioOut  (gpioOut),
        .irqTimer (irqTimer)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        chk;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[14];

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // one bus cycle: inputs change on the falling edge, the write lands
    // on the following rising edge
    task automatic wr(logic [31:0] a, logic [31:0] d);
        @(negedge clk);
        dmWe = 1'b1;
        dmAddr = a;
        dmWData = d;
    endtask

    // one bus cycle: read and compare the state left by the last rising edge
    task automatic rd(logic [31:0] a, logic [31:0] exp, string nm);
        @(negedge clk);
        dmWe = 1'b0;
        dmAddr = a;
        dmWData = 32'd0;
        #1;
        check(nm, dmRData, exp);
    endtask

    task automatic idle();
        @(negedge clk);
        dmWe = 1'b0;
        dmAddr = 32'd0;
    endtask

    initial begin
        vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0, "ram_wr"};
        vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0, 1'b1, 32'hDEAD_BEEF, "ram_rd"};
        vecs[2]  = '{1'b0, 32'h0000_0110, 32'h0, 1'b1, 32'hDEAD_BEEF, "ram_alias"};
        vecs[3]  = '{1'b0, 32'h0FFF_FF13, 32'h0, 1'b1, 32'hDEAD_BEEF, "ram_alias_hi"};
        vecs[4]  = '{1'b1, 32'h0000_0014, 32'h0000_0011, 1'b0, 32'h0, "ram_wr2"};
        vecs[5]  = '{1'b1, 32'h0000_0014, 32'h0000_0022, 1'b1, 32'h0000_0011, "ram_wr_old"};
        vecs[6]  = '{1'b0, 32'h0000_0014, 32'h0, 1'b1, 32'h0000_0022, "ram_wr_new"};
        vecs[7]  = '{1'b1, 32'h4000_0010, 32'h1234_5678, 1'b0, 32'h0, "unmap_wr"};
        vecs[8]  = '{1'b0, 32'h4000_0010, 32'h0, 1'b1, 32'h0, "unmap_rd"};
        vecs[9]  = '{1'b0, 32'h0000_0010, 32'h0, 1'b1, 32'hDEAD_BEEF, "ram_untouched"};
        vecs[10] = '{1'b1, 32'h8000_0024, 32'hFFFF_FFFF, 1'b0, 32'h0, "off9_wr"};
        vecs[11] = '{1'b0, 32'h8000_0024, 32'h0, 1'b1, 32'h0, "off9_rd"};
        vecs[12] = '{1'b1, A_CTRL, 32'hFFFF_FFF8, 1'b0, 32'h0, "ctrl_unused_wr"};
        vecs[13] = '{1'b0, A_CTRL, 32'h0, 1'b1, 32'h0, "ctrl_unused_rd"};

        rst_n = 1'b0;
        dmWe = 1'b0;
        dmAddr = 32'd0;
        dmWData = 32'd0;
        gpioIn = 16'd0;
        repeat (2) @(negedge clk);
        check("rst_gpioOut", {16'd0, gpioOut}, 32'd0);
        check("rst_irq", {31'd0, irqTimer}, 32'd0);
        dmAddr = A_CNT;
        #1;
        check("rst_cnt", dmRData, 32'd0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            dmWe = vecs[i].we;
            dmAddr = vecs[i].addr;
            dmWData = vecs[i].wdata;
            #1;
            if (vecs[i].chk)
                check(vecs[i].name, dmRData, vecs[i].exp);
        end

        wr(A_GOUT, 32'h0001_A5A5);
        rd(A_GOUT, 32'h0000_A5A5, "gpio_out_rd");
        check("gpio_out_pin", {16'd0, gpioOut}, 32'h0000_A5A5);

        @(negedge clk);
        dmWe = 1'b0;
        dmAddr = A_GIN;
        gpioIn = 16'h1234;
        @(posedge clk);
        #1;
        check("gpio_in_1clk", dmRData, 32'd0);
        @(posedge clk);
        #1;
        check("gpio_in_2clk", dmRData, 32'h0000_1234);

        wr(A_PRE, 32'd2);
        wr(A_CMP, 32'd5);
        wr(A_CNT, 32'd0);
        wr(A_CTRL, 32'h7);
        for (int j = 0; j < 19; j++) begin
            rd(A_STAT, (j == 18) ? 32'd1 : 32'd0, "tmr_match_time");
            if (j == 18)
                check("tmr_irq_not_yet", {31'd0, irqTimer}, 32'd0);
        end
        rd(A_CNT, 32'd0, "tmr_autoreload");
        check("tmr_irq_rise", {31'd0, irqTimer}, 32'd1);
        wr(A_STAT, 32'd1);
        rd(A_STAT, 32'd0, "tmr_w1c");
        check("tmr_irq_lag", {31'd0, irqTimer}, 32'd1);
        idle();
        #1;
        check("tmr_irq_fall", {31'd0, irqTimer}, 32'd0);

        wr(A_CTRL, 32'd0);
        wr(A_PRE, 32'd0);
        wr(A_CMP, 32'd0);
        wr(A_CNT, 32'd0);
        wr(A_STAT, 32'd1);
        wr(A_CTRL, 32'd1);
        wr(A_CNT, 32'd100);
        rd(A_CNT, 32'd100, "prio_cnt_wr");
        rd(A_STAT, 32'd0, "prio_no_match");

        wr(A_CTRL, 32'd0);
        wr(A_CNT, 32'd0);
        wr(A_STAT, 32'd1);
        wr(A_CTRL, 32'd3);
        idle();
        wr(A_STAT, 32'd1);
        rd(A_STAT, 32'd1, "prio_set_wins");
        wr(A_CTRL, 32'd0);
        wr(A_STAT, 32'd1);
        rd(A_STAT, 32'd0, "w1c_idle");

        wr(A_CNT, 32'hFFFF_FFFF);
        wr(A_CMP, 32'd7);
        wr(A_CTRL, 32'd1);
        rd(A_CNT, 32'hFFFF_FFFF, "wrap_before");
        rd(A_CNT, 32'd0, "wrap_after");
        rd(A_CNT, 32'd1, "wrap_next");

        wr(A_CMP, 32'd0);
        wr(A_CNT, 32'd0);
        wr(A_CTRL, 32'h7);
        repeat (4) idle();
        check("pre_rst_irq", {31'd0, irqTimer}, 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        dmAddr = A_CTRL;
        #1;
        check("rst_mid_irq", {31'd0, irqTimer}, 32'd0);
        check("rst_mid_gpio", {16'd0, gpioOut}, 32'd0);
        check("rst_mid_ctrl", dmRData, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) idle();
        rd(A_CNT, 32'd0, "rst_idle_cnt");
        rd(A_STAT, 32'd0, "rst_idle_stat");
        rd(A_CMP, 32'd0, "rst_idle_cmp");
        check("rst_idle_irq", {31'd0, irqTimer}, 32'd0);
        rd(A_GOUT, 32'd0, "rst_gout_reg");
        rd(32'h0000_0010, 32'hDEAD_BEEF, "ram_keeps");

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
